score_keeper: RTL and testbench

Match-control and scoring stage that sits directly upstream of the two-digit score display refresher. It consumes goal events from the ball/collision logic and the START button. It produces the 2-bit p1_score/p2_score values the display multiplexes, plus play-enable, serve and game-over controls for the ball and paddle logic. It owns the match state machine: idle, rally, post-goal pause, game over.

---
 rtl/pong_pkg.sv | 7 +
 rtl/score_keeper_rise_detect.sv | 18 +
 rtl/score_keeper.sv | 94 +++++++++
 tb/tb_score_keeper.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared match-state encoding, score width and winner codes.
package pong_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  localparam int SCORE_W = 2;
  localparam logic WIN_P1 = 1'b0;
  localparam logic WIN_P2 = 1'b1;
endpackage

// File: rtl/score_keeper_rise_detect.sv
// rise_detect: registered one-cycle pulse on each rising edge of d.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= d;
      pulse <= d & ~prev;
    end
  end
endmodule

// File: rtl/score_keeper.sv
// score_keeper: match FSM, score registers and post-goal pause timer.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 3,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int PCNT_W       = 26
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               play_en,
  output logic               serve,
  output logic               game_over,
  output logic               winner
);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [PCNT_W-1:0]  PLAST = PCNT_W'(PAUSE_CYCLES - 1);

  state_t state, state_n;
  logic st_ev, g1_ev, g2_ev;
  logic [PCNT_W-1:0] cnt;
  logic [SCORE_W-1:0] p1_inc, p2_inc, p1_n, p2_n;
  logic winner_n, play_n, serve_n, over_n;

  rise_detect u_start (.clk(CLK), .rst(RESET), .d(START),   .pulse(st_ev));
  rise_detect u_g1    (.clk(CLK), .rst(RESET), .d(goal_p1), .pulse(g1_ev));
  rise_detect u_g2    (.clk(CLK), .rst(RESET), .d(goal_p2), .pulse(g2_ev));

  assign p1_inc = p1_score + SCORE_W'(1);
  assign p2_inc = p2_score + SCORE_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == PAUSE) ? cnt + PCNT_W'(1) : '0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = st_ev ? PLAY : IDLE;
      PLAY: begin
        if (g1_ev && g2_ev) state_n = PAUSE;
        else if (g1_ev)     state_n = (p1_inc == WIN) ? OVER : PAUSE;
        else if (g2_ev)     state_n = (p2_inc == WIN) ? OVER : PAUSE;
      end
      PAUSE: state_n = (cnt == PLAST) ? PLAY : PAUSE;
      OVER:  state_n = st_ev ? PLAY : OVER;
    endcase
  end

  always_comb begin
    p1_n     = p1_score;
    p2_n     = p2_score;
    winner_n = winner;
    if (state == PLAY && g1_ev && !g2_ev) p1_n = p1_inc;
    if (state == PLAY && g2_ev && !g1_ev) p2_n = p2_inc;
    if (state == OVER && st_ev) begin
      p1_n = '0;
      p2_n = '0;
    end
    if (state == PLAY && state_n == OVER) winner_n = g2_ev ? WIN_P2 : WIN_P1;
    play_n  = state_n == PLAY;
    serve_n = state_n == PLAY && state != PLAY;
    over_n  = state_n == OVER;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      p1_score  <= '0;
      p2_score  <= '0;
      winner    <= WIN_P1;
      play_en   <= 1'b0;
      serve     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      p1_score  <= p1_n;
      p2_score  <= p2_n;
      winner    <= winner_n;
      play_en   <= play_n;
      serve     <= serve_n;
      game_over <= over_n;
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed stimulus queues expected output changes; a monitor pops one per observed change.
module tb_score_keeper;
  logic clk = 1'b0;
  logic RESET = 1'b1, START = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
  logic [1:0] p1_score, p2_score;
  logic play_en, serve, game_over, winner;

  score_keeper #(.WIN_SCORE(3), .PAUSE_CYCLES(4), .PCNT_W(3)) dut (
    .CLK(clk), .RESET(RESET), .START(START), .goal_p1(goal_p1), .goal_p2(goal_p2),
    .p1_score(p1_score), .p2_score(p2_score), .play_en(play_en), .serve(serve),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int cyc = 0, base = 0, checks = 0, errors = 0;
  bit armed = 0, first = 1;
  logic [7:0] cur, prev;

  always @(posedge clk) cyc <= cyc + 1;

  // vector = {p1, p2, play_en, serve, game_over, winner (only meaningful while over)}
  always @(negedge clk) begin
    if (armed) begin
      cur = {p1_score, p2_score, play_en, serve, game_over, game_over & winner};
      if (first || cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.v !== cur || e.cyc != cyc) begin
            errors++;
            $display("FAIL output_change got=%b@%0d want=%b@%0d", cur, cyc, e.v, e.cyc);
          end
        end
      end
      prev  = cur;
      first = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int dc, input logic [7:0] v);
    q.push_back('{base + dc, v});
  endtask

  task automatic goal(input bit p2, input logic [1:0] s1, input logic [1:0] s2);
    base = cyc;
    if (p2) goal_p2 = 1'b1; else goal_p1 = 1'b1;
    expect_at(2, {s1, s2, 4'b0000});
    expect_at(6, {s1, s2, 4'b1100});
    expect_at(7, {s1, s2, 4'b1000});
    tick(1);
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    tick(9);
  endtask

  initial begin
    tick(3);
    RESET = 1'b0;
    base = cyc;
    expect_at(0, 8'b0);
    armed = 1;
    // start from IDLE with a long-held button
    base = cyc;
    START = 1'b1;
    expect_at(2, {2'd0, 2'd0, 4'b1100});
    expect_at(3, {2'd0, 2'd0, 4'b1000});
    tick(10);
    START = 1'b0;
    tick(3);
    // held goal counts once, pause is four cycles, still held at resume
    base = cyc;
    goal_p1 = 1'b1;
    expect_at(2, {2'd1, 2'd0, 4'b0000});
    expect_at(6, {2'd1, 2'd0, 4'b1100});
    expect_at(7, {2'd1, 2'd0, 4'b1000});
    tick(20);
    goal_p1 = 1'b0;
    tick(3);
    START = 1'b1;
    tick(2);
    START = 1'b0;
    tick(3);
    // P2 scores twice, with a START press during each pause
    for (int i = 1; i <= 2; i++) begin
      base = cyc;
      goal_p2 = 1'b1;
      expect_at(2, {2'd1, 2'(i), 4'b0000});
      expect_at(6, {2'd1, 2'(i), 4'b1100});
      expect_at(7, {2'd1, 2'(i), 4'b1000});
      tick(1);
      goal_p2 = 1'b0;
      tick(2);
      START = 1'b1;
      tick(1);
      START = 1'b0;
      tick(7);
    end
    // third P2 goal wins; display stays frozen
    base = cyc;
    goal_p2 = 1'b1;
    expect_at(2, {2'd1, 2'd3, 4'b0011});
    tick(1);
    goal_p2 = 1'b0;
    tick(100);
    // restart from OVER
    base = cyc;
    START = 1'b1;
    expect_at(2, {2'd0, 2'd0, 4'b1100});
    expect_at(3, {2'd0, 2'd0, 4'b1000});
    tick(2);
    START = 1'b0;
    tick(3);
    // simultaneous goals: replay, no score
    base = cyc;
    goal_p1 = 1'b1;
    goal_p2 = 1'b1;
    expect_at(2, {2'd0, 2'd0, 4'b0000});
    expect_at(6, {2'd0, 2'd0, 4'b1100});
    expect_at(7, {2'd0, 2'd0, 4'b1000});
    tick(1);
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    tick(9);
    // build 2/1, then reset in the middle of the pause
    goal(0, 2'd1, 2'd0);
    goal(0, 2'd2, 2'd0);
    base = cyc;
    goal_p2 = 1'b1;
    expect_at(2, {2'd2, 2'd1, 4'b0000});
    tick(1);
    goal_p2 = 1'b0;
    tick(2);
    RESET = 1'b1;
    expect_at(4, 8'b0);
    tick(1);
    RESET = 1'b0;
    // goals in IDLE are ignored
    goal_p1 = 1'b1;
    tick(2);
    goal_p1 = 1'b0;
    goal_p2 = 1'b1;
    tick(2);
    goal_p2 = 1'b0;
    tick(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations left=%0d want=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
